sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single SRAM-like memory port between the instruction-fetch master (inst_*) and the MEM-stage data master (data_*).
- Arbitrates address-phase requests and routes addr_ok back to the granted master. Tracks the one outstanding transaction and returns data_ok/rdata to its owner.
- Sits between the pipeline (IF and EXE/MEM stages) and the memory-side bridge.
- Data has priority. A starvation counter guarantees instruction-fetch progress.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants, while inst_req is pending, after which inst gets priority for one grant.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request
- inst_wr  in  1  write flag (always 0 from IF, forwarded anyway)
- inst_size  in  2  access size
- inst_wstrb  in  4  byte strobe
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  fetch address accepted
- inst_data_ok  out  1  fetch data returned
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request
- data_wr  in  1  store flag
- data_size  in  2  access size
- data_wstrb  in  4  byte strobe
- data_addr  in  32  address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  load data returned / store complete
- data_rdata  out  32  load data
- mem_req  out  1  request to memory side
- mem_wr  out  1  forwarded write flag
- mem_size  out  2  forwarded size
- mem_wstrb  out  4  forwarded strobe
- mem_addr  out  32  forwarded address
- mem_wdata  out  32  forwarded write data
- mem_addr_ok  in  1  memory accepted address
- mem_data_ok  in  1  memory data phase done
- mem_rdata  in  32  memory read data

Behaviour:
- Clocking and reset: clk is the clock; reset is synchronous, active-high.
- Reset state:
  - state=IDLE, lock=0, owner=0, starve_cnt=0.
  - mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are all 0.
- FSM states: IDLE (no transaction outstanding) and WAIT (one transaction accepted, awaiting data_ok).
- Single outstanding transaction: no new address is issued in WAIT, including in the cycle mem_data_ok arrives.
- Selection in IDLE (combinational sel, 1 = data):
  - If lock=1, sel = locked_sel.
  - Else if both requests are active and starve_cnt==STARVE_LIMIT, sel = inst.
  - Else if data_req=1, sel = data.
  - Else sel = inst.
- Forwarding in IDLE:
  - mem_req = selected req.
  - mem_wr, mem_size, mem_wstrb, mem_addr and mem_wdata are muxed from the selected master.
  - In WAIT, mem_req=0 (other mem_* fields don't-care).
- addr_ok routing:
  - Only in IDLE.
  - inst_addr_ok = mem_addr_ok & sel==inst & inst_req.
  - data_addr_ok = mem_addr_ok & sel==data & data_req.
  - The unselected master never sees addr_ok.
- Lock (request stability):
  - If mem_req=1 and mem_addr_ok=0 in IDLE, set lock=1 and locked_sel=sel, so the grant cannot switch to the other master mid-handshake.
  - Clear lock on acceptance.
  - Also clear lock if the locked master drops req, which is a protocol violation: fall back to normal arbitration next cycle.
- Acceptance (mem_req & mem_addr_ok):
  - owner <= sel; state <= WAIT.
  - Starvation update: if sel=data and inst_req=1, starve_cnt <= starve_cnt+1, saturating at STARVE_LIMIT. If sel=inst, starve_cnt <= 0. Otherwise unchanged.
- In WAIT, when mem_data_ok=1:
  - inst_data_ok = (owner==inst); data_data_ok = (owner==data). Both are combinational, same cycle as mem_data_ok.
  - state <= IDLE.
- rdata: inst_rdata and data_rdata = mem_rdata, broadcast. Only meaningful with the corresponding data_ok.
- Spurious response: mem_data_ok in IDLE is ignored; no data_ok is asserted to either master.
- Latency: zero-cycle combinational request path. Minimum 1 cycle from accept to data_ok; back-to-back throughput is one transaction per 2 cycles.
- Reset mid-WAIT: returns to IDLE, and any later mem_data_ok for the dropped transaction is ignored.

Test Plan:
- Single fetch: inst_req=1, addr=0x1c000000; mem_addr_ok=1 same cycle; mem_data_ok with rdata=0x02800000 two cycles later -> inst_addr_ok=1 at cycle 0, mem_req=0 in WAIT, inst_data_ok=1 with inst_rdata=0x02800000, data_data_ok=0.
- Simultaneous requests: inst_req=data_req=1, data_addr=0x100, wr=1, wstrb=0xF -> mem_addr=0x100, mem_wr=1, data_addr_ok=1 only. After data_ok, the next grant goes to inst.
- Lock: inst alone requests, mem_addr_ok=0 for 3 cycles, data_req rises at cycle 1 -> mem_addr stays at inst_addr all 3 cycles. Accept at cycle 3 goes to inst, then data is served.
- Starvation: data_req held high, inst_req high, STARVE_LIMIT=4 -> 4 data grants, then 5th grant to inst, starve_cnt returns to 0.
- Spurious/reset: mem_data_ok=1 in IDLE -> both data_ok=0. Assert reset while in WAIT, then mem_data_ok=1 -> no data_ok, state IDLE, all outputs 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the data master.
// Data has priority, and a starvation counter makes sure fetch still gets through.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          lock_q, lock_d;
  logic          locked_sel_q, locked_sel_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          sel;
  logic          sel_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lock_q       <= 1'b0;
      locked_sel_q <= 1'b0;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      locked_sel_q <= locked_sel_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // sel: 1 selects the data master
  always_comb begin
    if (lock_q)
      sel = locked_sel_q;
    else if (inst_req && data_req && starve_cnt_q == LIMIT_C)
      sel = 1'b0;
    else
      sel = data_req;
  end

  assign sel_req    = sel ? data_req : inst_req;
  assign mem_wr     = sel ? data_wr    : inst_wr;
  assign mem_size   = sel ? data_size  : inst_size;
  assign mem_wstrb  = sel ? data_wstrb : inst_wstrb;
  assign mem_addr   = sel ? data_addr  : inst_addr;
  assign mem_wdata  = sel ? data_wdata : inst_wdata;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    locked_sel_d = locked_sel_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req      = sel_req;
        inst_addr_ok = mem_addr_ok & ~sel & inst_req;
        data_addr_ok = mem_addr_ok & sel & data_req;
        if (sel_req && mem_addr_ok) begin
          state_d = WAIT;
          owner_d = sel;
          lock_d  = 1'b0;
          if (!sel)
            starve_cnt_d = '0;
          else if (inst_req && starve_cnt_q != LIMIT_C)
            starve_cnt_d = starve_cnt_q + CW'(1);
        end else if (sel_req) begin
          lock_d       = 1'b1;
          locked_sel_d = sel;
        end else begin
          // locked master withdrew its request: rearbitrate next cycle
          lock_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          inst_data_ok = ~owner_q;
          data_data_ok = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      mem_req      = 1'b0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of who should own the memory port.
module tb_sram_port_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: who holds the outstanding transaction (-1 none, 0 inst, 1 data),
  // which master a stalled handshake is committed to, and how many data grants
  // in a row have gone by while fetch was waiting.
  int m_out    = -1;
  int m_commit = -1;
  int m_streak = 0;
  int last_grant = -1;

  logic        s_inst_aok, s_data_aok, s_inst_dok, s_data_dok, s_mem_req;
  logic [31:0] s_mem_addr;

  task automatic clear_inputs();
    reset = 0;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_addr = 32'h1c000000; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic step();
    int  win;
    bit  wreq, e_mreq, e_iaok, e_daok, e_idok, e_ddok;
    #2;
    e_mreq = 0; e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0;
    win = 0; wreq = 0;
    if (!reset) begin
      if (m_out >= 0) begin
        e_idok = mem_data_ok && m_out == 0;
        e_ddok = mem_data_ok && m_out == 1;
      end else begin
        if (m_commit >= 0) win = m_commit;
        else if (inst_req && data_req && m_streak == LIMIT) win = 0;
        else win = data_req ? 1 : 0;
        wreq   = (win == 1) ? data_req : inst_req;
        e_mreq = wreq;
        e_iaok = wreq && mem_addr_ok && win == 0;
        e_daok = wreq && mem_addr_ok && win == 1;
      end
    end
    check("mem_req", {31'b0, mem_req}, {31'b0, e_mreq});
    check("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, e_iaok});
    check("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, e_daok});
    check("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, e_idok});
    check("data_data_ok", {31'b0, data_data_ok}, {31'b0, e_ddok});
    if (e_idok) check("inst_rdata", inst_rdata, mem_rdata);
    if (e_ddok) check("data_rdata", data_rdata, mem_rdata);
    if (e_mreq) begin
      check("mem_addr",  mem_addr,  win == 1 ? data_addr  : inst_addr);
      check("mem_wdata", mem_wdata, win == 1 ? data_wdata : inst_wdata);
      check("mem_ctl", {25'b0, mem_wr, mem_size, mem_wstrb},
            win == 1 ? {25'b0, data_wr, data_size, data_wstrb} : {25'b0, inst_wr, inst_size, inst_wstrb});
    end
    s_inst_aok = inst_addr_ok; s_data_aok = data_addr_ok; s_inst_dok = inst_data_ok;
    s_data_dok = data_data_ok; s_mem_req = mem_req; s_mem_addr = mem_addr;
    if (reset) begin
      m_out = -1; m_commit = -1; m_streak = 0;
    end else if (m_out >= 0) begin
      if (mem_data_ok) m_out = -1;
    end else if (wreq && mem_addr_ok) begin
      m_out = win; m_commit = -1; last_grant = win;
      if (win == 0) m_streak = 0;
      else if (inst_req && m_streak < LIMIT) m_streak++;
    end else if (wreq) begin
      m_commit = win;
    end else begin
      m_commit = -1;
    end
    @(posedge clk); #1;
  endtask

  // Accept one request in IDLE, then complete it; returns which master was granted.
  task automatic grant_and_complete(output int g);
    mem_addr_ok = 1; mem_data_ok = 0;
    last_grant = -1;
    step();
    g = last_grant;
    mem_addr_ok = 0; mem_data_ok = 1;
    step();
    mem_data_ok = 0;
  endtask

  initial begin
    int g;
    int exp_seq [6];
    exp_seq = '{1, 1, 1, 1, 0, 1};
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    step();
    reset = 0;

    // single fetch
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    step();
    check("t1_inst_aok", {31'b0, s_inst_aok}, 32'd1);
    inst_req = 0; mem_addr_ok = 0;
    step();
    check("t1_wait_mreq", {31'b0, s_mem_req}, 32'd0);
    mem_data_ok = 1; mem_rdata = 32'h02800000;
    step();
    check("t1_inst_dok", {31'b0, s_inst_dok}, 32'd1);
    check("t1_data_dok", {31'b0, s_data_dok}, 32'd0);
    check("t1_rdata", inst_rdata, 32'h02800000);
    mem_data_ok = 0;

    // simultaneous requests: data first, then fetch
    inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_addr = 32'h100; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hcafef00d;
    mem_addr_ok = 1;
    step();
    check("t2_mem_addr", s_mem_addr, 32'h100);
    check("t2_data_aok", {31'b0, s_data_aok}, 32'd1);
    check("t2_inst_aok", {31'b0, s_inst_aok}, 32'd0);
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    step();
    check("t2_data_dok", {31'b0, s_data_dok}, 32'd1);
    grant_and_complete(g);
    check("t2_next_inst", g, 0);
    inst_req = 0;

    // lock: stalled fetch handshake keeps the port while data shows up
    inst_req = 1; inst_addr = 32'h1c000040; mem_addr_ok = 0;
    step();
    check("t3_addr_c0", s_mem_addr, 32'h1c000040);
    data_req = 1; data_addr = 32'h200;
    step();
    check("t3_addr_c1", s_mem_addr, 32'h1c000040);
    step();
    check("t3_addr_c2", s_mem_addr, 32'h1c000040);
    grant_and_complete(g);
    check("t3_accept_inst", g, 0);
    inst_req = 0;
    grant_and_complete(g);
    check("t3_then_data", g, 1);

    // starvation: four data grants, then fetch, then data again
    inst_req = 1; data_req = 1;
    for (int i = 0; i < 6; i++) begin
      grant_and_complete(g);
      check($sformatf("t4_grant%0d", i), g, exp_seq[i]);
    end
    clear_inputs();

    // spurious response and reset during WAIT
    mem_data_ok = 1;
    step();
    check("t5_spur_i", {31'b0, s_inst_dok}, 32'd0);
    check("t5_spur_d", {31'b0, s_data_dok}, 32'd0);
    mem_data_ok = 0; data_req = 1; mem_addr_ok = 1;
    step();
    data_req = 0; mem_addr_ok = 0; reset = 1;
    step();
    reset = 0; mem_data_ok = 1;
    step();
    check("t5_rst_dok", {31'b0, s_data_dok | s_inst_dok}, 32'd0);
    check("t5_rst_mreq", {31'b0, s_mem_req}, 32'd0);
    mem_data_ok = 0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(99) == 0);
      inst_req    = ($urandom_range(3) != 0);
      data_req    = ($urandom_range(2) != 0);
      inst_wr     = $urandom_range(1);
      inst_size   = 2'($urandom_range(3));
      inst_wstrb  = 4'($urandom_range(15));
      inst_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wr     = $urandom_range(1);
      data_size   = 2'($urandom_range(3));
      data_wstrb  = 4'($urandom_range(15));
      data_addr   = $urandom;
      data_wdata  = $urandom;
      mem_addr_ok = $urandom_range(1);
      mem_data_ok = $urandom_range(1);
      mem_rdata   = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
